// File: rtl/seq_run_detector_if.sv
// Signal bundle for seq_run_detector: serial stream, clear, target pattern and detector results.
// master drives the stream side, slave is the detector.
interface seq_run_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic [PAT_W-1:0] pattern;
    logic [1:0]       out;
    logic             pat_hit;
    logic [CNT_W-1:0] event_cnt;

    modport master (
        output clear,
        output in_valid,
        output in_bit,
        output pattern,
        input  out,
        input  pat_hit,
        input  event_cnt
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  in_bit,
        input  pattern,
        output out,
        output pat_hit,
        output event_cnt
    );
endinterface

// File: rtl/seq_run_detector.sv
// Serial run detector with optional pattern matcher and saturating event counter.
// Define SEQ_RUN_DETECTOR_PATTERN_EN to build the pattern matcher; otherwise pat_hit is tied low.
//
//  state | meaning
//  ------+---------------------------------------------
//  IDLE  | no valid bit seen since reset/clear
//  ONES  | current run is of 1s, length in run_len_q
//  ZEROS | current run is of 0s, length in run_len_q
module seq_run_detector #(
    parameter int RUN_LEN = 2,
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    seq_run_detector_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONES  = 2'd1,
        ZEROS = 2'd2
    } state_t;

    localparam logic [7:0] RUN_MAX = 8'(RUN_LEN);

    state_t           state_q, state_d;
    logic [7:0]       run_len_q, run_len_d;
    logic [7:0]       run_len_inc;
    logic [1:0]       out_q, out_d;
    logic             pat_hit_q, pat_hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // run_len saturates at RUN_LEN so long runs keep flagging on every bit
    assign run_len_inc = (run_len_q >= RUN_MAX) ? RUN_MAX : run_len_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            run_len_q <= '0;
            out_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        out_d     = 2'b00;
        if (bus.clear) begin
            state_d   = IDLE;
            run_len_d = '0;
        end else if (bus.in_valid) begin
            case (state_q)
                IDLE: begin
                    state_d   = bus.in_bit ? ONES : ZEROS;
                    run_len_d = 8'd1;
                end
                ONES: begin
                    if (bus.in_bit) begin
                        run_len_d = run_len_inc;
                    end else begin
                        state_d   = ZEROS;
                        run_len_d = 8'd1;
                    end
                end
                ZEROS: begin
                    if (!bus.in_bit) begin
                        run_len_d = run_len_inc;
                    end else begin
                        state_d   = ONES;
                        run_len_d = 8'd1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    run_len_d = '0;
                end
            endcase
            if (run_len_d == RUN_MAX) begin
                if (state_d == ONES) begin
                    out_d = 2'b01;
                end else if (state_d == ZEROS) begin
                    out_d = 2'b11;
                end
            end
        end
    end

`ifdef SEQ_RUN_DETECTOR_PATTERN_EN
    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // fill keeps a freshly cleared all-zero history from matching a zero pattern
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_hit_d = 1'b0;
        if (bus.clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bus.in_valid) begin
            hist_d    = {hist_q[PAT_W-2:0], bus.in_bit};
            fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
            pat_hit_d = (fill_d == FILL_MAX) && (hist_d == bus.pattern);
        end
    end
`else
    logic unused_pattern;
    assign unused_pattern = ^bus.pattern;
    assign pat_hit_d      = 1'b0;
`endif

    // a run flag and a pattern hit on the same bit count as one event
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clear) begin
            cnt_d = '0;
        end else if (((out_d != 2'b00) || pat_hit_d) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_hit_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pat_hit_q <= pat_hit_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.pat_hit   = pat_hit_q;
    assign bus.event_cnt = cnt_q;
endmodule

// File: tb/tb_seq_run_detector.sv
// Self-checking bench for seq_run_detector: vector table, randomized stream vs model, and
// a narrow-counter instance for saturation and asynchronous reset.
module tb_seq_run_detector;
    localparam int RUN_LEN = 3;
    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;
`ifdef SEQ_RUN_DETECTOR_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif
    localparam logic [3:0] P = 4'b1011;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    seq_run_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W))  bus ();
    seq_run_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W2)) bus2 ();

    seq_run_detector #(.RUN_LEN(RUN_LEN), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_run_detector #(.RUN_LEN(RUN_LEN), .PAT_W(PAT_W), .CNT_W(CNT_W2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic       b;
        logic [3:0] pat;
        logic [1:0] eo;
        logic       eh;
    } vec_t;

    typedef struct {
        logic [1:0] eo;
        logic       eh;
        logic [7:0] ec;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic clr, input logic vld, input logic b,
                                input logic [3:0] pat, input logic [1:0] eo, input logic eh);
        vec_t v;
        v.clr = clr; v.vld = vld; v.b = b; v.pat = pat; v.eo = eo; v.eh = eh;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step1(input logic clr, input logic vld, input logic b, input logic [3:0] pat,
                         input exp_t e, input string name);
        exp_t x;
        bus.clear = clr; bus.in_valid = vld; bus.in_bit = b; bus.pattern = pat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({name, ".out"}, 32'(bus.out), 32'(x.eo));
        chk({name, ".pat_hit"}, 32'(bus.pat_hit), 32'(x.eh));
        chk({name, ".event_cnt"}, 32'(bus.event_cnt), 32'(x.ec));
    endtask

    task automatic step2(input logic vld, input logic b, input exp_t e, input string name);
        exp_t x;
        bus2.clear = 1'b0; bus2.in_valid = vld; bus2.in_bit = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({name, ".out"}, 32'(bus2.out), 32'(x.eo));
        chk({name, ".pat_hit"}, 32'(bus2.pat_hit), 32'(x.eh));
        chk({name, ".event_cnt"}, 32'(bus2.event_cnt), 32'({6'd0, x.ec[1:0]}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t       e;
        int         tcnt;
        logic       clr, vld, b, mpol;
        logic [3:0] pat, mhist;
        int         mrun, mfill, mcnt;

        rst = 1'b1; rst2 = 1'b1;
        bus.clear = 0; bus.in_valid = 0; bus.in_bit = 0; bus.pattern = P;
        bus2.clear = 0; bus2.in_valid = 0; bus2.in_bit = 0; bus2.pattern = P;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out", 32'(bus.out), 32'd0);
        chk("reset.pat_hit", 32'(bus.pat_hit), 32'd0);
        chk("reset.event_cnt", 32'(bus.event_cnt), 32'd0);
        chk("reset2.out", 32'(bus2.out), 32'd0);
        chk("reset2.event_cnt", 32'(bus2.event_cnt), 32'd0);
        rst = 1'b0; rst2 = 1'b0;

        // four ones
        add(1,0,0,P,2'b00,0);
        add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b01,0); add(0,1,1,P,2'b01,0);
        // 0,0,1,0,0,0
        add(1,0,0,P,2'b00,0);
        add(0,1,0,P,2'b00,0); add(0,1,0,P,2'b00,0); add(0,1,1,P,2'b00,0);
        add(0,1,0,P,2'b00,0); add(0,1,0,P,2'b00,0); add(0,1,0,P,2'b11,0);
        // overlapping pattern matches
        add(1,0,0,P,2'b00,0);
        add(0,1,1,P,2'b00,0); add(0,1,0,P,2'b00,0); add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b00,1);
        add(0,1,0,P,2'b00,0); add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b00,1);
        // idle gap inside a run; in_bit toggles while invalid
        add(1,0,0,P,2'b00,0);
        add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b00,0);
        for (int i = 0; i < 5; i++) add(0,0,i[0],P,2'b00,0);
        add(0,1,1,P,2'b01,0);
        // clear beats a simultaneous valid bit
        add(1,0,0,P,2'b00,0);
        add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b00,0);
        add(1,1,1,P,2'b00,0);
        add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b00,0);
        // long zero run then polarity switch
        add(1,0,0,P,2'b00,0);
        for (int i = 0; i < 5; i++) add(0,1,0,P,(i >= 2) ? 2'b11 : 2'b00,0);
        add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b00,0); add(0,1,1,P,2'b01,0);
        // fill gating: history equals pattern after one bit but fill is not full yet
        add(1,0,0,4'b0001,2'b00,0);
        add(0,1,1,4'b0001,2'b00,0); add(0,1,0,4'b0001,2'b00,0); add(0,1,0,4'b0001,2'b00,0);
        add(0,1,0,4'b0001,2'b11,0); add(0,1,1,4'b0001,2'b00,1);

        tcnt = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            e.eo = vecs[i].eo;
            e.eh = vecs[i].eh & PAT_ON;
            if (vecs[i].clr) tcnt = 0;
            else if ((e.eo != 2'b00) || e.eh) tcnt = (tcnt == 255) ? 255 : tcnt + 1;
            e.ec = 8'(tcnt);
            step1(vecs[i].clr, vecs[i].vld, vecs[i].b, vecs[i].pat, e, $sformatf("vec%0d", i));
        end

        // randomized stream against a behavioural model
        b = 1'b0; pat = P; mpol = 1'b0; mrun = 0; mhist = '0; mfill = 0; mcnt = 0;
        for (int i = 0; i < 400; i++) begin
            clr = (i == 0) || ($urandom_range(0, 39) == 0);
            vld = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 3) b = ~b;
            if ($urandom_range(0, 19) == 0) pat = 4'($urandom_range(0, 15));
            e.eo = 2'b00;
            e.eh = 1'b0;
            if (clr) begin
                mrun = 0; mhist = '0; mfill = 0; mcnt = 0;
            end else begin
                if (vld) begin
                    if (mrun == 0 || b != mpol) begin
                        mpol = b;
                        mrun = 1;
                    end else if (mrun < RUN_LEN) begin
                        mrun++;
                    end
                    if (mrun == RUN_LEN) e.eo = mpol ? 2'b01 : 2'b11;
                    mhist = {mhist[2:0], b};
                    if (mfill < PAT_W) mfill++;
                    e.eh = PAT_ON && (mfill == PAT_W) && (mhist == pat);
                end
                if (((e.eo != 2'b00) || e.eh) && mcnt < 255) mcnt++;
            end
            e.ec = 8'(mcnt);
            step1(clr, vld, b, pat, e, $sformatf("rnd%0d", i));
        end
        bus.clear = 0; bus.in_valid = 0;

        // narrow counter saturates at 3
        for (int i = 0; i < 7; i++) begin
            e.eo = (i >= 2) ? 2'b01 : 2'b00;
            e.eh = 1'b0;
            e.ec = (i >= 4) ? 8'd3 : ((i >= 2) ? 8'(i - 1) : 8'd0);
            step2(1'b1, 1'b1, e, $sformatf("sat%0d", i));
        end

        // asynchronous reset mid-run, observed before the next edge
        bus2.in_valid = 1'b1; bus2.in_bit = 1'b1;
        #3;
        rst2 = 1'b1;
        #1;
        chk("async_rst.out", 32'(bus2.out), 32'd0);
        chk("async_rst.pat_hit", 32'(bus2.pat_hit), 32'd0);
        chk("async_rst.event_cnt", 32'(bus2.event_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e.eo = (i == 2) ? 2'b01 : 2'b00;
            e.eh = 1'b0;
            e.ec = (i == 2) ? 8'd1 : 8'd0;
            step2(1'b1, 1'b1, e, $sformatf("post_rst%0d", i));
        end
        bus2.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_run_detector.md
SEQ_RUN_DETECTOR -- requirements
Module: seq_run_detector

Interface
REQ-001 SHALL have parameter RUN_LEN, default 2, run length (consecutive identical bits) that flags a run; legal range 2..255.
REQ-002 SHALL have parameter PAT_W, default 4, pattern matcher width in bits; legal range 2..16.
REQ-003 SHALL have parameter CNT_W, default 8, width of the event counter.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port clear  input  1  synchronous clear of FSM, history and counter.
REQ-007 SHALL have port in_valid  input  1  qualifies in_bit; bit is consumed only when high.
REQ-008 SHALL have port in_bit  input  1  serial data bit.
REQ-009 SHALL have port pattern  input  PAT_W  target pattern, MSB = oldest bit; sampled every cycle.
REQ-010 SHALL have port out  output  2  run flag: 00 none, 01 ones run, 11 zeros run, 10 never driven.
REQ-011 SHALL have port pat_hit  output  1  one-cycle pulse on pattern match.
REQ-012 SHALL have port event_cnt  output  CNT_W  count of run-flag and pattern events.

Function
REQ-013 FSM SHALL have states IDLE, ONES, ZEROS; run counter run_len (8 bits) tracks current run length.
REQ-014 IDLE + valid bit b: go to ONES if b=1 else ZEROS; run_len=1.
REQ-015 ONES/ZEROS + valid bit equal to current polarity: stay; run_len=min(run_len+1, RUN_LEN).
REQ-016 ONES/ZEROS + valid bit of opposite polarity: switch state; run_len=1.
REQ-017 in_valid low: FSM, run_len, history unchanged.
REQ-018 out SHALL be registered: on the edge consuming a valid bit, out=01 if the updated run is ones with run_len==RUN_LEN, 11 if zeros with run_len==RUN_LEN, else 00.
REQ-019 out SHALL be 00 on every edge where in_valid is low (one flag per consumed bit).
REQ-020 Runs longer than RUN_LEN SHALL flag on every further consumed bit (overlapping, saturating run_len).
REQ-021 Pattern matcher SHALL keep a PAT_W-bit shift history (new bit into LSB) and a fill count saturating at PAT_W.
REQ-022 pat_hit SHALL pulse for one cycle, on the edge consuming a valid bit, when fill==PAT_W after the shift and history==pattern; overlapping matches allowed.
REQ-023 event_cnt SHALL increment by 1 on each edge where the new out!=00 or new pat_hit=1 (both together count once), saturating at all-ones.
REQ-024 clear=1 SHALL force IDLE, run_len=0, history=0, fill=0, event_cnt=0, out=00, pat_hit=0 on the next edge; clear wins over a simultaneous valid bit (bit discarded).

Reset
REQ-025 rst high SHALL immediately force state IDLE, run_len=0, history=0, fill=0, out=00, pat_hit=0, event_cnt=0.
REQ-026 Reset mid-run SHALL discard all partial run and pattern progress; first valid bit after release behaves as from IDLE.

Configuration
REQ-027 Macro SEQ_RUN_DETECTOR_PATTERN_EN SHALL gate the pattern matcher.
REQ-028 With macro defined: REQ-021/022 behaviour, pat_hit contributes to event_cnt.
REQ-029 Without macro: history/fill logic absent, pattern port ignored, pat_hit tied 0, event_cnt counts run flags only; port list unchanged.

Verification (RUN_LEN=3, PAT_W=4, pattern=4'b1011, macro defined)
REQ-030 Valid bits 1,1,1,1 -> out 00,00,01,01; event_cnt ends at 2.
REQ-031 Valid bits 0,0,1,0,0,0 -> out 00,00,00,00,00,11; FSM ends ZEROS.
REQ-032 Valid bits 1,0,1,1,0,1,1 -> pat_hit on 4th and 7th bits (overlap); out 00 throughout; event_cnt=2.
REQ-033 Bits 1,1 then in_valid low 5 cycles then 1 -> out 00 during gap, 01 on third valid bit.
REQ-034 Bits 1,1 then clear together with valid 1, then 1,1 -> no flag on cleared bit, out 00,00 after; event_cnt=0.
REQ-035 CNT_W=2, 6 consecutive valid 1s -> event_cnt saturates at 3; async rst asserted mid-stream -> all outputs 0 before next edge.
